// File: rtl/sched_pkg.sv
// Shared opcode constants, opcode-class helpers and the issue bundle
// for the warp scheduler.
package sched_pkg;

  localparam int PKT_WARP_W = 2;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd2;
  localparam logic [3:0] OP_MMA   = 4'd3;
  localparam logic [3:0] OP_LDI   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd15;

  typedef struct packed {
    logic [PKT_WARP_W-1:0] warp;
    logic [3:0]            opcode;
    logic [3:0]            target_reg;
    logic [3:0]            address_reg;
    logic [3:0]            imm_short;
    logic [1:0]            array_id;
  } issue_pkt_t;

  function automatic logic writes_reg(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_MMA) || (op == OP_LDI);
  endfunction

  function automatic logic reads_addr(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_MMA);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set bit of req starting at ptr, wrapping.
// Ports: req, ptr in; grant (one-hot), grant_idx, any out.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         any
);

  logic [W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = W'((int'(ptr) + k) % N);
      if (!any && req[idx]) begin
        any       = 1'b1;
        grant_idx = idx;
      end
    end
    grant[grant_idx] = any;
  end

endmodule

// File: rtl/warp_scheduler.sv
// Warp scheduler: tracks buffer slots, requests refills, issues one
// eligible warp per cycle round-robin under a per-warp scoreboard.
// Ports: buffer snoop + buffer outputs, active mask, fetch req
// handshake, issue handshake + fields, writeback, done/overflow.
module warp_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int NUM_REGS  = 16,
  parameter int WARP_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      buffer_write_en,
  input  logic [WARP_W-1:0]         warp_num_store,
  input  logic [NUM_WARPS-1:0][3:0] opcode_in,
  input  logic [NUM_WARPS-1:0][3:0] target_reg_in,
  input  logic [NUM_WARPS-1:0][3:0] address_reg_in,
  input  logic [NUM_WARPS-1:0][3:0] imm_short_in,
  input  logic [NUM_WARPS-1:0][1:0] array_id_in,
  input  logic [NUM_WARPS-1:0]      warp_active_mask,
  output logic                      fetch_req_valid,
  output logic [WARP_W-1:0]         fetch_req_warp,
  input  logic                      fetch_req_ready,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [WARP_W-1:0]         issue_warp,
  output logic [3:0]                issue_opcode,
  output logic [3:0]                issue_target_reg,
  output logic [3:0]                issue_address_reg,
  output logic [3:0]                issue_imm_short,
  output logic [1:0]                issue_array_id,
  input  logic                      wb_en,
  input  logic [WARP_W-1:0]         wb_warp,
  input  logic [3:0]                wb_reg,
  output logic [NUM_WARPS-1:0]      warp_done,
  output logic                      all_done,
  output logic                      overflow_err
);

  typedef logic [NUM_WARPS-1:0][NUM_REGS-1:0] sb_t;

  logic [NUM_WARPS-1:0] slot_full, req_pending;
  logic [NUM_WARPS-1:0] full_n, pend_n, done_n;
  logic [NUM_WARPS-1:0] elig, issue_gnt, wr_hot;
  logic [NUM_WARPS-1:0] fetch_cand, fetch_gnt;
  logic [NUM_WARPS-1:0] fetch_hot_q, acc_hot, clr_hot;
  sb_t                  scoreboard, sb_n;
  logic [WARP_W-1:0]    rr_ptr, sel_idx, fetch_idx;
  logic                 sel_any, fetch_any;
  logic                 load, fire, ovf_hit;
  issue_pkt_t           pkt_d, pkt_q;

  always_comb begin
    elig = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      elig[w] = slot_full[w] && warp_active_mask[w]
        && !warp_done[w]
        && !scoreboard[w][target_reg_in[w]]
        && !(reads_addr(opcode_in[w])
             && scoreboard[w][address_reg_in[w]]);
    end
  end

  rr_arbiter #(.N(NUM_WARPS), .W(WARP_W)) u_issue_arb (
    .req       (elig),
    .ptr       (rr_ptr),
    .grant     (issue_gnt),
    .grant_idx (sel_idx),
    .any       (sel_any)
  );

  assign load = !issue_valid || issue_ready;
  assign fire = load && sel_any;

  always_comb begin
    pkt_d             = '0;
    pkt_d.warp        = sel_idx;
    pkt_d.opcode      = opcode_in[sel_idx];
    pkt_d.target_reg  = target_reg_in[sel_idx];
    pkt_d.address_reg = address_reg_in[sel_idx];
    pkt_d.imm_short   = imm_short_in[sel_idx];
    pkt_d.array_id    = array_id_in[sel_idx];
  end

  // A write landing on the slot that drains this same edge is legal.
  assign ovf_hit = buffer_write_en
    && slot_full[warp_num_store]
    && !(fire && sel_idx == warp_num_store);

  assign acc_hot = fetch_hot_q
    & {NUM_WARPS{fetch_req_valid && fetch_req_ready}};
  assign clr_hot = fire ? issue_gnt : '0;

  always_comb begin
    wr_hot = '0;
    wr_hot[warp_num_store] = buffer_write_en;
    full_n = (slot_full & ~clr_hot) | wr_hot;
    pend_n = (req_pending | acc_hot) & ~wr_hot;
    done_n = warp_done;
    if (fire && pkt_d.opcode == OP_HALT) done_n = warp_done | issue_gnt;
    // Clear first so a same-cycle set on the same bit wins.
    sb_n = scoreboard;
    if (wb_en) sb_n[wb_warp][wb_reg] = 1'b0;
    if (fire && writes_reg(pkt_d.opcode))
      sb_n[sel_idx][pkt_d.target_reg] = 1'b1;
  end

  // Refill choice looks at post-edge state so a just-written or
  // just-accepted slot is never requested twice.
  assign fetch_cand = ~full_n & ~pend_n & ~done_n;

  rr_arbiter #(.N(NUM_WARPS), .W(WARP_W)) u_fetch_arb (
    .req       (fetch_cand),
    .ptr       ('0),
    .grant     (fetch_gnt),
    .grant_idx (fetch_idx),
    .any       (fetch_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_full       <= '0;
      req_pending     <= '0;
      warp_done       <= '0;
      scoreboard      <= '0;
      rr_ptr          <= '0;
      overflow_err    <= 1'b0;
      issue_valid     <= 1'b0;
      pkt_q           <= '0;
      fetch_req_valid <= 1'b0;
      fetch_req_warp  <= '0;
      fetch_hot_q     <= '0;
    end else begin
      slot_full   <= full_n;
      req_pending <= pend_n;
      warp_done   <= done_n;
      scoreboard  <= sb_n;
      if (ovf_hit) overflow_err <= 1'b1;
      if (load) begin
        issue_valid <= sel_any;
        if (sel_any) begin
          pkt_q  <= pkt_d;
          rr_ptr <= sel_idx + WARP_W'(1);
        end
      end
      if (!fetch_req_valid || fetch_req_ready) begin
        fetch_req_valid <= fetch_any;
        if (fetch_any) begin
          fetch_req_warp <= fetch_idx;
          fetch_hot_q    <= fetch_gnt;
        end
      end
    end
  end

  assign issue_warp        = pkt_q.warp;
  assign issue_opcode      = pkt_q.opcode;
  assign issue_target_reg  = pkt_q.target_reg;
  assign issue_address_reg = pkt_q.address_reg;
  assign issue_imm_short   = pkt_q.imm_short;
  assign issue_array_id    = pkt_q.array_id;
  assign all_done          = &warp_done;

endmodule

// File: tb/tb_warp_scheduler.sv
// Bench for warp_scheduler: directed scenarios plus a randomized run
// against a cycle-level reference model of the scheduling rules.
module tb_warp_scheduler;
  import sched_pkg::*;

  localparam int NW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              buffer_write_en;
  logic [1:0]        warp_num_store;
  logic [NW-1:0][3:0] opcode_in, target_reg_in;
  logic [NW-1:0][3:0] address_reg_in, imm_short_in;
  logic [NW-1:0][1:0] array_id_in;
  logic [NW-1:0]     warp_active_mask;
  logic              fetch_req_valid, fetch_req_ready;
  logic [1:0]        fetch_req_warp;
  logic              issue_valid, issue_ready;
  logic [1:0]        issue_warp, issue_array_id;
  logic [3:0]        issue_opcode, issue_target_reg;
  logic [3:0]        issue_address_reg, issue_imm_short;
  logic              wb_en;
  logic [1:0]        wb_warp;
  logic [3:0]        wb_reg;
  logic [NW-1:0]     warp_done;
  logic              all_done, overflow_err;

  warp_scheduler dut (
    .clk               (clk),
    .reset             (reset),
    .buffer_write_en   (buffer_write_en),
    .warp_num_store    (warp_num_store),
    .opcode_in         (opcode_in),
    .target_reg_in     (target_reg_in),
    .address_reg_in    (address_reg_in),
    .imm_short_in      (imm_short_in),
    .array_id_in       (array_id_in),
    .warp_active_mask  (warp_active_mask),
    .fetch_req_valid   (fetch_req_valid),
    .fetch_req_warp    (fetch_req_warp),
    .fetch_req_ready   (fetch_req_ready),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .issue_warp        (issue_warp),
    .issue_opcode      (issue_opcode),
    .issue_target_reg  (issue_target_reg),
    .issue_address_reg (issue_address_reg),
    .issue_imm_short   (issue_imm_short),
    .issue_array_id    (issue_array_id),
    .wb_en             (wb_en),
    .wb_warp           (wb_warp),
    .wb_reg            (wb_reg),
    .warp_done         (warp_done),
    .all_done          (all_done),
    .overflow_err      (overflow_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit        m_full[NW], m_pend[NW], m_done[NW];
  bit [15:0] m_sb[NW];
  int        m_rr, m_iw, m_fw;
  bit        m_iv, m_fv, m_ovf;
  bit [3:0]  m_op, m_tgt, m_adr, m_imm;
  bit [1:0]  m_aid;

  // data the buffer takes on a write
  bit [3:0] p_op, p_tgt, p_adr, p_imm;
  bit [1:0] p_aid;

  function automatic void model_reset();
    for (int w = 0; w < NW; w++) begin
      m_full[w] = 0; m_pend[w] = 0;
      m_done[w] = 0; m_sb[w] = '0;
    end
    m_rr = 0; m_iw = 0; m_fw = 0;
    m_iv = 0; m_fv = 0; m_ovf = 0;
    m_op = 0; m_tgt = 0; m_adr = 0; m_imm = 0; m_aid = 0;
  endfunction

  function automatic bit m_elig(int w);
    bit rd;
    rd = opcode_in[w] inside {OP_LOAD, OP_STORE, OP_MMA};
    return m_full[w] && warp_active_mask[w] && !m_done[w]
      && !m_sb[w][target_reg_in[w]]
      && !(rd && m_sb[w][address_reg_in[w]]);
  endfunction

  task automatic tick();
    bit        ld, fnd, nf, n_iv, n_fv, n_ovf;
    int        sel, nfw, ws, n_rr, n_iw;
    bit        n_full[NW], n_pend[NW], n_done[NW];
    bit [15:0] n_sb[NW];
    bit [3:0]  n_op, n_tgt, n_adr, n_imm;
    bit [1:0]  n_aid;
    n_full = m_full; n_pend = m_pend;
    n_done = m_done; n_sb = m_sb;
    n_iv = m_iv; n_iw = m_iw; n_rr = m_rr;
    n_op = m_op; n_tgt = m_tgt; n_adr = m_adr;
    n_imm = m_imm; n_aid = m_aid;
    n_fv = m_fv; nfw = m_fw; n_ovf = m_ovf;
    sel = 0; fnd = 0;
    ld = !m_iv || issue_ready;
    if (ld) begin
      for (int k = 0; k < NW; k++)
        if (!fnd && m_elig((m_rr + k) % NW)) begin
          fnd = 1; sel = (m_rr + k) % NW;
        end
      n_iv = fnd;
    end
    if (wb_en) n_sb[wb_warp][wb_reg] = 1'b0;
    if (fnd) begin
      n_iw = sel;
      n_op = opcode_in[sel]; n_tgt = target_reg_in[sel];
      n_adr = address_reg_in[sel]; n_imm = imm_short_in[sel];
      n_aid = array_id_in[sel];
      n_full[sel] = 0;
      n_rr = (sel + 1) % NW;
      if (n_op inside {OP_LOAD, OP_MMA, OP_LDI}) n_sb[sel][n_tgt] = 1;
      if (n_op == OP_HALT) n_done[sel] = 1;
    end
    if (m_fv && fetch_req_ready) n_pend[m_fw] = 1;
    ws = int'(warp_num_store);
    if (buffer_write_en) begin
      if (m_full[ws] && !(fnd && sel == ws)) n_ovf = 1;
      n_full[ws] = 1; n_pend[ws] = 0;
    end
    if (!m_fv || fetch_req_ready) begin
      nf = 0;
      for (int w = 0; w < NW; w++)
        if (!nf && !n_full[w] && !n_pend[w] && !n_done[w]) begin
          nf = 1; nfw = w;
        end
      n_fv = nf;
    end
    @(posedge clk);
    m_full = n_full; m_pend = n_pend; m_done = n_done; m_sb = n_sb;
    m_iv = n_iv; m_iw = n_iw; m_rr = n_rr;
    m_op = n_op; m_tgt = n_tgt; m_adr = n_adr;
    m_imm = n_imm; m_aid = n_aid;
    m_fv = n_fv; m_fw = nfw; m_ovf = n_ovf;
    if (buffer_write_en) begin
      opcode_in[ws] = p_op; target_reg_in[ws] = p_tgt;
      address_reg_in[ws] = p_adr; imm_short_in[ws] = p_imm;
      array_id_in[ws] = p_aid;
    end
    #1;
  endtask

  task automatic wr(int w, bit [3:0] op, bit [3:0] tgt,
                    bit [3:0] adr, bit [3:0] imm, bit [1:0] aid);
    buffer_write_en = 1; warp_num_store = 2'(w);
    p_op = op; p_tgt = tgt; p_adr = adr; p_imm = imm; p_aid = aid;
    tick();
    buffer_write_en = 0;
  endtask

  task automatic apply_reset();
    reset = 1;
    buffer_write_en = 0; warp_num_store = 0;
    wb_en = 0; wb_warp = 0; wb_reg = 0;
    issue_ready = 0; fetch_req_ready = 0;
    warp_active_mask = '1;
    opcode_in = '0; target_reg_in = '0; address_reg_in = '0;
    imm_short_in = '0; array_id_in = '0;
    model_reset();
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({issue_valid, fetch_req_valid, warp_done, all_done,
         overflow_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outs: got %b want 0", {issue_valid,
               fetch_req_valid, warp_done, all_done, overflow_err});
    end
    tick();
    n_cmp++;
    if ({fetch_req_valid, fetch_req_warp} !== {1'b1, 2'd0}) begin
      n_bad++;
      $display("FAIL fetch_first: got %b/%0d want 1/0",
               fetch_req_valid, fetch_req_warp);
    end
    fetch_req_ready = 1;
    tick();
    n_cmp++;
    if ({fetch_req_valid, fetch_req_warp} !== {1'b1, 2'd1}) begin
      n_bad++;
      $display("FAIL fetch_next: got %b/%0d want 1/1",
               fetch_req_valid, fetch_req_warp);
    end
    fetch_req_ready = 0;
  endtask

  task automatic test_order();
    bit [1:0] ew;
    apply_reset();
    issue_ready = 1;
    wr(0, OP_NOP, 0, 0, 0, 0);
    for (int w = 1; w <= 4; w++) begin
      if (w < 4) wr(w, OP_NOP, 4'(w), 0, 0, 0);
      else tick();
      ew = 2'(w - 1);
      n_cmp++;
      if ({issue_valid, issue_warp} !== {1'b1, ew}) begin
        n_bad++;
        $display("FAIL order_%0d: got %b/%0d want 1/%0d",
                 w - 1, issue_valid, issue_warp, ew);
      end
    end
    tick();
    n_cmp++;
    if (issue_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL order_drain: got %b want 0", issue_valid);
    end
  endtask

  task automatic test_scoreboard();
    apply_reset();
    issue_ready = 1;
    wr(1, OP_LOAD, 5, 0, 1, 0);
    tick();
    n_cmp++;
    if ({issue_valid, issue_warp, issue_opcode} !==
        {1'b1, 2'd1, OP_LOAD}) begin
      n_bad++;
      $display("FAIL sb_load: got %b/%0d/%0d want 1/1/1",
               issue_valid, issue_warp, issue_opcode);
    end
    wr(1, OP_STORE, 5, 2, 2, 1);
    repeat (3) tick();
    n_cmp++;
    if (issue_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL sb_block: got %b want 0", issue_valid);
    end
    wb_en = 1; wb_warp = 1; wb_reg = 5;
    tick();
    wb_en = 0;
    n_cmp++;
    if (issue_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL sb_wb_edge: got %b want 0", issue_valid);
    end
    tick();
    n_cmp++;
    if ({issue_valid, issue_warp, issue_opcode} !==
        {1'b1, 2'd1, OP_STORE}) begin
      n_bad++;
      $display("FAIL sb_store: got %b/%0d/%0d want 1/1/2",
               issue_valid, issue_warp, issue_opcode);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    issue_ready = 0;
    wr(0, OP_NOP, 7, 9, 11, 3);
    for (int w = 1; w < 4; w++) wr(w, OP_NOP, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({issue_valid, issue_warp, issue_opcode, issue_target_reg,
           issue_address_reg, issue_imm_short, issue_array_id,
           dut.slot_full} !==
          {1'b1, 2'd0, OP_NOP, 4'd7, 4'd9, 4'd11, 2'd3, 4'b1110}) begin
        n_bad++;
        $display("FAIL stall_hold_%0d: got %b/%0d tgt %0d slots %b",
                 c, issue_valid, issue_warp, issue_target_reg,
                 dut.slot_full);
      end
    end
    issue_ready = 1;
    tick();
    n_cmp++;
    if ({issue_valid, issue_warp} !== {1'b1, 2'd1}) begin
      n_bad++;
      $display("FAIL stall_release: got %b/%0d want 1/1",
               issue_valid, issue_warp);
    end
  endtask

  task automatic test_mask();
    bit [1:0] seq [4];
    seq = '{2'd1, 2'd3, 2'd0, 2'd2};
    apply_reset();
    issue_ready = 1;
    warp_active_mask = 4'b0000;
    for (int w = 0; w < 4; w++) wr(w, OP_NOP, 0, 0, 0, 0);
    n_cmp++;
    if (issue_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mask_none: got %b want 0", issue_valid);
    end
    warp_active_mask = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        tick();
        n_cmp++;
        if (issue_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL mask_gap: got %b want 0", issue_valid);
        end
        warp_active_mask = 4'b1111;
      end
      tick();
      n_cmp++;
      if ({issue_valid, issue_warp} !== {1'b1, seq[i]}) begin
        n_bad++;
        $display("FAIL mask_seq_%0d: got %b/%0d want 1/%0d",
                 i, issue_valid, issue_warp, seq[i]);
      end
    end
  endtask

  task automatic test_halt();
    bit [3:0] exp;
    apply_reset();
    issue_ready = 1;
    exp = 4'b0000;
    wr(0, OP_HALT, 0, 0, 0, 0);
    for (int w = 1; w <= 4; w++) begin
      if (w < 4) wr(w, OP_HALT, 0, 0, 0, 0);
      else tick();
      exp[w - 1] = 1'b1;
      n_cmp++;
      if ({warp_done, all_done} !== {exp, (w == 4)}) begin
        n_bad++;
        $display("FAIL halt_done_%0d: got %b/%b want %b",
                 w - 1, warp_done, all_done, exp);
      end
    end
    fetch_req_ready = 1;
    repeat (3) tick();
    n_cmp++;
    if (fetch_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL halt_no_fetch: got %b want 0", fetch_req_valid);
    end
    fetch_req_ready = 0;
  endtask

  task automatic test_overflow_reset();
    apply_reset();
    issue_ready = 1;
    warp_active_mask = 4'b0000;
    wr(2, OP_NOP, 0, 0, 0, 0);
    n_cmp++;
    if (overflow_err !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_first: got %b want 0", overflow_err);
    end
    wr(2, OP_NOP, 1, 0, 0, 0);
    repeat (2) tick();
    n_cmp++;
    if (overflow_err !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_sticky: got %b want 1", overflow_err);
    end
    warp_active_mask = 4'b0100;
    tick();
    n_cmp++;
    if ({issue_valid, issue_warp} !== {1'b1, 2'd2}) begin
      n_bad++;
      $display("FAIL ovf_issue: got %b/%0d want 1/2",
               issue_valid, issue_warp);
    end
    #1 reset = 1;
    #1;
    n_cmp++;
    if ({issue_valid, issue_warp, issue_opcode, issue_target_reg,
         issue_address_reg, issue_imm_short, issue_array_id,
         fetch_req_valid, fetch_req_warp, warp_done, all_done,
         overflow_err} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got v%b ovf%b fetch%b",
               issue_valid, overflow_err, fetch_req_valid);
    end
    apply_reset();
  endtask

  task automatic test_random();
    int w;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      w = $urandom_range(0, 3);
      issue_ready = ($urandom_range(0, 3) != 0);
      fetch_req_ready = 1'($urandom_range(0, 1));
      warp_active_mask = ($urandom_range(0, 3) == 0) ?
                         4'($urandom) : 4'hF;
      buffer_write_en = 0;
      if ($urandom_range(0, 1) == 1 && !m_full[w]) begin
        buffer_write_en = 1; warp_num_store = 2'(w);
        p_op = 4'($urandom_range(0, 4));
        p_tgt = 4'($urandom_range(0, 3));
        p_adr = 4'($urandom_range(0, 3));
        p_imm = 4'($urandom); p_aid = 2'($urandom);
      end
      wb_en = ($urandom_range(0, 2) == 0);
      wb_warp = 2'($urandom);
      wb_reg = 4'($urandom_range(0, 3));
      tick();
      n_cmp++;
      if (issue_valid !== m_iv) begin
        n_bad++;
        $display("FAIL rnd_valid c%0d: got %b want %b",
                 c, issue_valid, m_iv);
      end
      if (m_iv) begin
        n_cmp++;
        if ({issue_warp, issue_opcode, issue_target_reg,
             issue_address_reg, issue_imm_short, issue_array_id} !==
            {2'(m_iw), m_op, m_tgt, m_adr, m_imm, m_aid}) begin
          n_bad++;
          $display("FAIL rnd_fields c%0d: got w%0d op%0d want w%0d op%0d",
                   c, issue_warp, issue_opcode, m_iw, m_op);
        end
      end
      n_cmp++;
      if (fetch_req_valid !== m_fv ||
          (m_fv && fetch_req_warp !== 2'(m_fw))) begin
        n_bad++;
        $display("FAIL rnd_fetch c%0d: got %b/%0d want %b/%0d",
                 c, fetch_req_valid, fetch_req_warp, m_fv, m_fw);
      end
      n_cmp++;
      if (overflow_err !== m_ovf) begin
        n_bad++;
        $display("FAIL rnd_ovf c%0d: got %b want %b",
                 c, overflow_err, m_ovf);
      end
    end
    buffer_write_en = 0; wb_en = 0;
  endtask

  initial begin
    reset = 1;
    test_reset();
    test_order();
    test_scoreboard();
    test_stall();
    test_mask();
    test_halt();
    test_overflow_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
